axi_scratchpad_resp: RTL and testbench



---
 rtl/axi_scratchpad_resp.sv | 265 ++++++++++++++++++++++++++
 tb/tb_axi_scratchpad_resp.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_scratchpad_resp.sv
// AXI4 responder backed by a flop scratchpad: one read or write burst at a time,
// round-robin between AR and AW, per-beat DECERR/SLVERR and a worst-case B response.

// Minimal AXI struct package for the core's memory-side port. It lets the responder build on its own.
package ariane_axi;
  localparam int unsigned AddrWidth = 64;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned IdWidth   = 4;
  localparam int unsigned StrbWidth = DataWidth / 8;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [AddrWidth-1:0] addr;
    logic [7:0]           len;
    logic [2:0]           size;
    logic [1:0]           burst;
  } ax_chan_t;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [StrbWidth-1:0] strb;
    logic                 last;
  } w_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0] id;
    logic [1:0]         resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdWidth-1:0]   id;
    logic [DataWidth-1:0] data;
    logic [1:0]           resp;
    logic                 last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

module axi_scratchpad_resp #(
  parameter int unsigned            AxiAddrWidth = 64,
  parameter int unsigned            AxiDataWidth = 64,
  parameter int unsigned            AxiIdWidth   = 4,
  parameter type                    noc_req_t    = ariane_axi::req_t,
  parameter type                    noc_resp_t   = ariane_axi::resp_t,
  parameter int unsigned            MemBytes     = 4096,
  parameter logic [AxiAddrWidth-1:0] BaseAddr    = 64'h8000_0000
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  noc_req_t  noc_req_i,
  output noc_resp_t noc_resp_o,
  output logic      busy_o
);

  localparam int unsigned StrbWidth = AxiDataWidth / 8;
  localparam int unsigned ByteLsb   = $clog2(StrbWidth);
  localparam int unsigned Words     = MemBytes / StrbWidth;
  localparam int unsigned IdxWidth  = $clog2(Words);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_WRESP = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic                    aw_ready_q, aw_ready_d;
  logic                    ar_ready_q, ar_ready_d;
  logic                    last_write_q, last_write_d;
  logic [AxiIdWidth-1:0]   id_q;
  logic [AxiAddrWidth-1:0] addr_q;
  logic [7:0]              len_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [7:0]              beat_q;
  logic                    past_len_q;
  logic [1:0]              resp_q;

  logic [AxiDataWidth-1:0] mem [Words];

  // DECERR outranks SLVERR outranks OKAY, which matches their numeric order.
  function automatic logic [1:0] worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [AxiAddrWidth-1:0] offset, step, next_addr;
  logic                    in_range, burst_ok, last_beat;
  logic [IdxWidth-1:0]     word_idx;
  logic [1:0]              beat_err, beat_resp;
  logic                    ar_hs, aw_hs, r_hs, w_hs, b_hs, frame_err, write_en;

  // Unsigned subtraction wraps below BaseAddr, so one compare covers both range ends.
  assign offset    = addr_q - BaseAddr;
  assign in_range  = offset < AxiAddrWidth'(MemBytes);
  assign word_idx  = offset[ByteLsb +: IdxWidth];
  assign burst_ok  = (burst_q == BURST_FIXED) || (burst_q == BURST_INCR);
  assign beat_err  = !in_range ? RESP_DECERR :
                     ((size_q > 3'(ByteLsb)) || !burst_ok) ? RESP_SLVERR : RESP_OKAY;
  assign step      = AxiAddrWidth'(1) << size_q;
  assign next_addr = (burst_q == BURST_FIXED) ? addr_q : ((addr_q & ~(step - 1'b1)) + step);
  assign last_beat = (beat_q == len_q);

  assign ar_hs = ar_ready_q && noc_req_i.ar_valid;
  assign aw_hs = aw_ready_q && noc_req_i.aw_valid;
  assign r_hs  = (state_q == ST_READ)  && noc_req_i.r_ready;
  assign w_hs  = (state_q == ST_WRITE) && noc_req_i.w_valid;
  assign b_hs  = (state_q == ST_WRESP) && noc_req_i.b_ready;

  assign frame_err = last_beat ? !noc_req_i.w.last : noc_req_i.w.last;
  assign beat_resp = worst(beat_err, frame_err ? RESP_SLVERR : RESP_OKAY);
  assign write_en  = w_hs && !past_len_q && (beat_err == RESP_OKAY);

  // Address readies are registered: the grant is decided one cycle ahead from the
  // pending valids, so neither ready depends combinationally on its own valid.
  always_comb begin
    logic offer;
    logic pick_write;
    state_d      = state_q;
    aw_ready_d   = 1'b0;
    ar_ready_d   = 1'b0;
    last_write_d = last_write_q;
    offer        = 1'b0;
    pick_write   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          state_d      = ST_WRITE;
          last_write_d = 1'b1;
        end else if (ar_hs) begin
          state_d      = ST_READ;
          last_write_d = 1'b0;
        end else begin
          offer = 1'b1;
        end
      end
      ST_READ: begin
        if (r_hs && last_beat) begin
          state_d = ST_IDLE;
          offer   = 1'b1;
        end
      end
      ST_WRITE: begin
        if (w_hs && noc_req_i.w.last) state_d = ST_WRESP;
      end
      ST_WRESP: begin
        if (b_hs) begin
          state_d = ST_IDLE;
          offer   = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (offer) begin
      pick_write = noc_req_i.aw_valid && (!noc_req_i.ar_valid || !last_write_q);
      aw_ready_d = pick_write;
      ar_ready_d = noc_req_i.ar_valid && !pick_write;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      aw_ready_q   <= 1'b0;
      ar_ready_q   <= 1'b0;
      last_write_q <= 1'b0;
      id_q         <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      beat_q       <= '0;
      past_len_q   <= 1'b0;
      resp_q       <= RESP_OKAY;
    end else begin
      state_q      <= state_d;
      aw_ready_q   <= aw_ready_d;
      ar_ready_q   <= ar_ready_d;
      last_write_q <= last_write_d;
      if (aw_hs) begin
        id_q       <= noc_req_i.aw.id;
        addr_q     <= noc_req_i.aw.addr;
        len_q      <= noc_req_i.aw.len;
        size_q     <= noc_req_i.aw.size;
        burst_q    <= noc_req_i.aw.burst;
        beat_q     <= '0;
        past_len_q <= 1'b0;
        resp_q     <= RESP_OKAY;
      end else if (ar_hs) begin
        id_q    <= noc_req_i.ar.id;
        addr_q  <= noc_req_i.ar.addr;
        len_q   <= noc_req_i.ar.len;
        size_q  <= noc_req_i.ar.size;
        burst_q <= noc_req_i.ar.burst;
        beat_q  <= '0;
      end else if (r_hs) begin
        addr_q <= next_addr;
        beat_q <= beat_q + 8'd1;
      end else if (w_hs && !past_len_q) begin
        // Once beat len passes without w_last, later beats are only drained.
        addr_q <= next_addr;
        beat_q <= beat_q + 8'd1;
        resp_q <= worst(resp_q, beat_resp);
        if (last_beat && !noc_req_i.w.last) past_len_q <= 1'b1;
      end
    end
  end

  // Contents deliberately survive reset; writes at a reset edge are dropped.
  always_ff @(posedge clk_i) begin
    if (rst_ni && write_en) begin
      for (int b = 0; b < int'(StrbWidth); b++) begin
        if (noc_req_i.w.strb[b]) mem[word_idx][8*b +: 8] <= noc_req_i.w.data[8*b +: 8];
      end
    end
  end

  always_comb begin
    noc_resp_o          = '0;
    noc_resp_o.aw_ready = aw_ready_q;
    noc_resp_o.ar_ready = ar_ready_q;
    noc_resp_o.w_ready  = (state_q == ST_WRITE);
    noc_resp_o.r_valid  = (state_q == ST_READ);
    noc_resp_o.b_valid  = (state_q == ST_WRESP);
    if (state_q == ST_READ) begin
      noc_resp_o.r.id   = id_q;
      noc_resp_o.r.resp = beat_err;
      noc_resp_o.r.last = last_beat;
      noc_resp_o.r.data = (beat_err == RESP_OKAY) ? mem[word_idx] : '0;
    end
    if (state_q == ST_WRESP) begin
      noc_resp_o.b.id   = id_q;
      noc_resp_o.b.resp = resp_q;
    end
  end

  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: tb/tb_axi_scratchpad_resp.sv
// Directed bench for axi_scratchpad_resp: one task per scenario, inline checks,
// hand-computed expectations, single summary line.
module tb_axi_scratchpad_resp;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [1:0] FIXED  = 2'b00;
  localparam logic [1:0] INCR   = 2'b01;
  localparam logic [1:0] WRAP   = 2'b10;
  localparam int         TMO    = 100;

  logic              clk = 1'b0;
  logic              rst_n;
  ariane_axi::req_t  req;
  ariane_axi::resp_t resp;
  logic              busy;
  int                n_checks = 0;
  int                n_fails  = 0;

  always #5 clk = ~clk;

  axi_scratchpad_resp dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .noc_req_i (req),
    .noc_resp_o(resp),
    .busy_o    (busy)
  );

  // ---------------- driver tasks (inputs change on negedge) ----------------
  task automatic set_aw(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] burst, input logic [3:0] id);
    req.aw.addr = addr; req.aw.len = len; req.aw.size = size;
    req.aw.burst = burst; req.aw.id = id; req.aw_valid = 1'b1;
  endtask

  task automatic set_ar(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                        input logic [1:0] burst, input logic [3:0] id);
    req.ar.addr = addr; req.ar.len = len; req.ar.size = size;
    req.ar.burst = burst; req.ar.id = id; req.ar_valid = 1'b1;
  endtask

  // Returns at the negedge just after the address handshake edge.
  task automatic wait_grant(output logic got_aw, output logic got_ar);
    int t = 0;
    got_aw = 1'b0;
    got_ar = 1'b0;
    while (!resp.aw_ready && !resp.ar_ready && t < TMO) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= TMO) begin
      n_fails++;
      $display("FAIL grant_timeout: no address ready after %0d cycles", t);
    end else if (resp.aw_ready && resp.ar_ready) begin
      n_fails++;
      $display("FAIL grant_onehot: aw_ready=%b ar_ready=%b, required at most one high",
               resp.aw_ready, resp.ar_ready);
    end
    if (t < TMO) begin
      got_aw = resp.aw_ready;
      got_ar = resp.ar_ready && !resp.aw_ready;
      @(negedge clk);
      if (got_aw) req.aw_valid = 1'b0;
      if (got_ar) req.ar_valid = 1'b0;
    end
  endtask

  task automatic send_w(input logic [63:0] data, input logic [7:0] strb, input logic last);
    int t = 0;
    req.w.data = data; req.w.strb = strb; req.w.last = last; req.w_valid = 1'b1;
    while (!resp.w_ready && t < TMO) begin
      @(negedge clk);
      t++;
    end
    if (t >= TMO) begin
      n_checks++; n_fails++;
      $display("FAIL w_timeout: w_ready low for %0d cycles", t);
    end
    @(negedge clk);
    req.w_valid = 1'b0;
    req.w.last  = 1'b0;
  endtask

  task automatic recv_b(output logic [1:0] bresp, output logic [3:0] bid);
    int t = 0;
    req.b_ready = 1'b1;
    while (!resp.b_valid && t < TMO) begin
      @(negedge clk);
      t++;
    end
    bresp = resp.b.resp;
    bid   = resp.b.id;
    if (t >= TMO) begin
      n_checks++; n_fails++;
      bresp = 2'bxx;
      $display("FAIL b_timeout: b_valid low for %0d cycles", t);
    end
    @(negedge clk);
    req.b_ready = 1'b0;
  endtask

  task automatic recv_r(output logic [63:0] data, output logic [1:0] rresp,
                        output logic rlast, output logic [3:0] rid);
    int t = 0;
    req.r_ready = 1'b1;
    while (!resp.r_valid && t < TMO) begin
      @(negedge clk);
      t++;
    end
    data = resp.r.data; rresp = resp.r.resp; rlast = resp.r.last; rid = resp.r.id;
    if (t >= TMO) begin
      n_checks++; n_fails++;
      data = 'x; rresp = 2'bxx;
      $display("FAIL r_timeout: r_valid low for %0d cycles", t);
    end
    @(negedge clk);
    req.r_ready = 1'b0;
  endtask

  // Sends beats 0..last_beat with data0+i, w_last on last_beat, then collects B.
  task automatic write_burst(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                             input logic [3:0] id, input logic [63:0] data0, input logic [7:0] strb,
                             input int last_beat, output logic [1:0] bresp, output logic [3:0] bid);
    logic ga, gr;
    set_aw(addr, len, size, INCR, id);
    wait_grant(ga, gr);
    for (int i = 0; i <= last_beat; i++) send_w(data0 + 64'(i), strb, i == last_beat);
    recv_b(bresp, bid);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    req   = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({resp.aw_ready, resp.ar_ready, resp.w_ready, resp.r_valid, resp.b_valid, busy} !== 6'b0) begin
      n_fails++;
      $display("FAIL reset_ctrl: aw/ar/w_ready,r/b_valid,busy=%b required 000000",
               {resp.aw_ready, resp.ar_ready, resp.w_ready, resp.r_valid, resp.b_valid, busy});
    end
    n_checks++;
    if (resp.r !== '0 || resp.b !== '0) begin
      n_fails++;
      $display("FAIL reset_fields: r=%h b=%h required all zero", resp.r, resp.b);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_arbitration();
    logic ga, gr, rl;
    logic [1:0] rs;
    logic [3:0] id;
    logic [63:0] d;
    set_aw(64'h8000_0300, 8'd0, 3'd3, INCR, 4'd1);
    set_ar(64'h8000_0300, 8'd0, 3'd3, INCR, 4'd2);
    wait_grant(ga, gr);
    n_checks++;
    if (ga !== 1'b1) begin n_fails++; $display("FAIL arb_grant0: got_aw=%b required 1", ga); end
    send_w(64'hCAFE_0000_1234_5678, 8'hFF, 1'b1);
    n_checks++;
    if (resp.ar_ready !== 1'b0) begin n_fails++; $display("FAIL arb_ready_busy: ar_ready=%b required 0", resp.ar_ready); end
    set_aw(64'h8000_0308, 8'd0, 3'd3, INCR, 4'd3);
    recv_b(rs, id);
    n_checks++;
    if (rs !== OKAY || id !== 4'd1) begin n_fails++; $display("FAIL arb_b0: resp=%b id=%h required 00 1", rs, id); end
    wait_grant(ga, gr);
    n_checks++;
    if (gr !== 1'b1) begin n_fails++; $display("FAIL arb_grant1: got_ar=%b required 1", gr); end
    set_ar(64'h8000_0308, 8'd0, 3'd3, INCR, 4'd4);
    recv_r(d, rs, rl, id);
    n_checks++;
    if (d !== 64'hCAFE_0000_1234_5678 || id !== 4'd2) begin
      n_fails++; $display("FAIL arb_r1: data=%h id=%h required cafe000012345678 2", d, id);
    end
    wait_grant(ga, gr);
    n_checks++;
    if (ga !== 1'b1) begin n_fails++; $display("FAIL arb_grant2: got_aw=%b required 1", ga); end
    send_w(64'h0BEE_F000_0000_0308, 8'hFF, 1'b1);
    recv_b(rs, id);
    wait_grant(ga, gr);
    recv_r(d, rs, rl, id);
    n_checks++;
    if (d !== 64'h0BEE_F000_0000_0308 || id !== 4'd4 || rs !== OKAY) begin
      n_fails++; $display("FAIL arb_r2: data=%h id=%h resp=%b required 0beef00000000308 4 00", d, id, rs);
    end
  endtask

  task automatic test_single_write_read();
    logic ga, gr, rl;
    logic [1:0] rs;
    logic [3:0] id;
    logic [63:0] d;
    write_burst(64'h8000_0010, 8'd0, 3'd3, 4'd5, 64'h1122_3344_5566_7788, 8'hFF, 0, rs, id);
    n_checks++;
    if (rs !== OKAY || id !== 4'd5) begin n_fails++; $display("FAIL single_b: resp=%b id=%h required 00 5", rs, id); end
    set_ar(64'h8000_0010, 8'd0, 3'd3, INCR, 4'd6);
    wait_grant(ga, gr);
    n_checks++;
    if (resp.r_valid !== 1'b1) begin n_fails++; $display("FAIL single_r_latency: r_valid=%b one cycle after AR, required 1", resp.r_valid); end
    recv_r(d, rs, rl, id);
    n_checks++;
    if (d !== 64'h1122_3344_5566_7788 || rl !== 1'b1 || rs !== OKAY || id !== 4'd6) begin
      n_fails++; $display("FAIL single_r: data=%h last=%b resp=%b id=%h required 1122334455667788 1 00 6", d, rl, rs, id);
    end
    n_checks++;
    if (busy !== 1'b0) begin n_fails++; $display("FAIL single_idle: busy=%b after last R, required 0", busy); end
  endtask

  task automatic test_incr_backpressure();
    logic ga, gr, stalled, held_last;
    logic [1:0] rs;
    logic [3:0] id;
    logic [63:0] held;
    int beat = 0;
    set_aw(64'h8000_0100, 8'd3, 3'd3, INCR, 4'd7);
    wait_grant(ga, gr);
    n_checks++;
    if (resp.w_ready !== 1'b1) begin n_fails++; $display("FAIL incr_w_latency: w_ready=%b after AW, required 1", resp.w_ready); end
    for (int i = 0; i < 4; i++) send_w(64'h1111_0000_0000_0100 + 64'(i), 8'hFF, i == 3);
    n_checks++;
    if (resp.b_valid !== 1'b1) begin n_fails++; $display("FAIL incr_b_latency: b_valid=%b after w_last, required 1", resp.b_valid); end
    recv_b(rs, id);
    n_checks++;
    if (rs !== OKAY) begin n_fails++; $display("FAIL incr_b: resp=%b required 00", rs); end
    set_ar(64'h8000_0100, 8'd3, 3'd3, INCR, 4'd8);
    wait_grant(ga, gr);
    stalled = 1'b0; held = '0; held_last = 1'b0;
    for (int cyc = 0; cyc < 40 && beat < 4; cyc++) begin
      req.r_ready = (cyc % 2 == 1);
      if (resp.r_valid) begin
        if (stalled) begin
          n_checks++;
          if (resp.r.data !== held || resp.r.last !== held_last) begin
            n_fails++; $display("FAIL incr_r_stable: data=%h last=%b required %h %b", resp.r.data, resp.r.last, held, held_last);
          end
        end
        if (req.r_ready) begin
          n_checks++;
          if (resp.r.data !== 64'h1111_0000_0000_0100 + 64'(beat) || resp.r.last !== (beat == 3) || resp.r.resp !== OKAY) begin
            n_fails++; $display("FAIL incr_r_beat%0d: data=%h last=%b resp=%b required %h %b 00", beat,
                                resp.r.data, resp.r.last, resp.r.resp, 64'h1111_0000_0000_0100 + 64'(beat), beat == 3);
          end
          beat++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1; held = resp.r.data; held_last = resp.r.last;
        end
      end
      @(negedge clk);
    end
    req.r_ready = 1'b0;
    if (beat < 4) begin n_checks++; n_fails++; $display("FAIL incr_r_timeout: got %0d beats required 4", beat); end
  endtask

  task automatic test_strobes();
    logic ga, gr, rl;
    logic [1:0] rs;
    logic [3:0] id;
    logic [63:0] d;
    write_burst(64'h8000_0200, 8'd0, 3'd3, 4'd1, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 0, rs, id);
    write_burst(64'h8000_0203, 8'd0, 3'd0, 4'd1, 64'h0000_0000_AB00_0000, 8'h08, 0, rs, id);
    n_checks++;
    if (rs !== OKAY) begin n_fails++; $display("FAIL strb_b: resp=%b required 00", rs); end
    set_ar(64'h8000_0200, 8'd0, 3'd3, INCR, 4'd2);
    wait_grant(ga, gr);
    recv_r(d, rs, rl, id);
    n_checks++;
    if (d !== 64'hFFFF_FFFF_ABFF_FFFF) begin n_fails++; $display("FAIL strb_r: data=%h required ffffffffabffffff", d); end
  endtask

  task automatic test_errors();
    logic ga, gr, rl;
    logic [1:0] rs;
    logic [3:0] id;
    logic [63:0] d;
    set_ar(64'h0000_1000, 8'd0, 3'd3, INCR, 4'd9);
    wait_grant(ga, gr);
    recv_r(d, rs, rl, id);
    n_checks++;
    if (rs !== DECERR || d !== 64'h0 || rl !== 1'b1) begin
      n_fails++; $display("FAIL err_decerr_r: resp=%b data=%h last=%b required 11 0 1", rs, d, rl);
    end
    set_ar(64'h8000_0300, 8'd1, 3'd3, WRAP, 4'd9);
    wait_grant(ga, gr);
    for (int i = 0; i < 2; i++) begin
      recv_r(d, rs, rl, id);
      n_checks++;
      if (rs !== SLVERR || d !== 64'h0 || rl !== (i == 1)) begin
        n_fails++; $display("FAIL err_wrap_beat%0d: resp=%b data=%h last=%b required 10 0 %b", i, rs, d, rl, i == 1);
      end
    end
    write_burst(64'h8000_0400, 8'd3, 3'd3, 4'd2, 64'h4444_0000_0000_0000, 8'hFF, 1, rs, id);
    n_checks++;
    if (rs !== SLVERR) begin n_fails++; $display("FAIL err_early_last: b_resp=%b required 10", rs); end
    write_burst(64'h8000_0000, 8'd0, 3'd3, 4'd3, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF, 0, rs, id);
    write_burst(64'h8000_0FF8, 8'd1, 3'd3, 4'd3, 64'h7777_0000_0000_0000, 8'hFF, 1, rs, id);
    n_checks++;
    if (rs !== DECERR) begin n_fails++; $display("FAIL err_cross_b: b_resp=%b required 11", rs); end
    set_ar(64'h8000_0000, 8'd0, 3'd3, INCR, 4'd3);
    wait_grant(ga, gr);
    recv_r(d, rs, rl, id);
    n_checks++;
    if (d !== 64'hDEAD_BEEF_0BAD_F00D) begin n_fails++; $display("FAIL err_cross_nowrite: word0=%h required deadbeef0badf00d", d); end
    set_ar(64'h8000_0FF8, 8'd1, 3'd3, INCR, 4'd3);
    wait_grant(ga, gr);
    recv_r(d, rs, rl, id);
    n_checks++;
    if (rs !== OKAY || d !== 64'h7777_0000_0000_0000) begin
      n_fails++; $display("FAIL err_cross_r0: resp=%b data=%h required 00 7777000000000000", rs, d);
    end
    recv_r(d, rs, rl, id);
    n_checks++;
    if (rs !== DECERR || d !== 64'h0 || rl !== 1'b1) begin
      n_fails++; $display("FAIL err_cross_r1: resp=%b data=%h last=%b required 11 0 1", rs, d, rl);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic ga, gr, rl;
    logic [1:0] rs;
    logic [3:0] id;
    logic [63:0] d;
    set_ar(64'h8000_0100, 8'd7, 3'd3, INCR, 4'd10);
    wait_grant(ga, gr);
    recv_r(d, rs, rl, id);
    recv_r(d, rs, rl, id);
    n_checks++;
    if (d !== 64'h1111_0000_0000_0101 || resp.r_valid !== 1'b1) begin
      n_fails++; $display("FAIL rst_pre: beat1 data=%h r_valid=%b required 1111000000000101 1", d, resp.r_valid);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (resp.r_valid !== 1'b0 || busy !== 1'b0) begin
      n_fails++; $display("FAIL rst_mid: r_valid=%b busy=%b required 0 0", resp.r_valid, busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    set_ar(64'h8000_0010, 8'd0, 3'd3, INCR, 4'd11);
    wait_grant(ga, gr);
    recv_r(d, rs, rl, id);
    n_checks++;
    if (d !== 64'h1122_3344_5566_7788 || rs !== OKAY || rl !== 1'b1 || id !== 4'd11) begin
      n_fails++; $display("FAIL rst_after: data=%h resp=%b last=%b id=%h required 1122334455667788 00 1 b", d, rs, rl, id);
    end
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_single_write_read();
    test_incr_backpressure();
    test_strobes();
    test_errors();
    test_reset_mid_burst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
